// File: rtl/regfile_arbiter.sv
// Round-robin arbiter and sequencer sharing one storage register among N_REQ requesters.
// Each grant runs a short write or read sequence on the register's control inputs and returns a done pulse.
module regfile_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_wr,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   gnt,
  output logic               done,
  output logic [W-1:0]       rd_data,
  output logic               rd_valid,
  output logic               rd_err,
  output logic               rf_mode,
  output logic               rf_din,
  output logic [W-1:0]       rf_in,
  output logic               rf_reset,
  input  logic [W-1:0]       rf_out
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  typedef enum logic [2:0] {IDLE, WR, RD_SETUP, RD_CAP, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] gnt_idx, gnt_idx_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic             loaded, loaded_nxt;
  logic             rst_q;
  logic [N_REQ-1:0] gnt_nxt;
  logic             done_nxt, rd_valid_nxt, rd_err_nxt, rf_mode_nxt, rf_din_nxt;
  logic [W-1:0]     rd_data_nxt, rf_in_nxt;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;

  // Outputs are registered from the next-state decode so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt_idx  <= '0;
      rr_ptr   <= '0;
      loaded   <= 1'b0;
      gnt      <= '0;
      done     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rf_mode  <= 1'b0;
      rf_din   <= 1'b0;
      rf_in    <= '0;
      rst_q    <= 1'b1;
      rf_reset <= 1'b1;
    end else begin
      state    <= state_nxt;
      gnt_idx  <= gnt_idx_nxt;
      rr_ptr   <= rr_ptr_nxt;
      loaded   <= loaded_nxt;
      gnt      <= gnt_nxt;
      done     <= done_nxt;
      rd_data  <= rd_data_nxt;
      rd_valid <= rd_valid_nxt;
      rd_err   <= rd_err_nxt;
      rf_mode  <= rf_mode_nxt;
      rf_din   <= rf_din_nxt;
      rf_in    <= rf_in_nxt;
      rst_q    <= 1'b0;
      rf_reset <= rst_q;  // holds the register in reset one cycle past deassertion
    end
  end

  always_comb begin
    state_nxt    = state;
    gnt_idx_nxt  = gnt_idx;
    rr_ptr_nxt   = rr_ptr;
    loaded_nxt   = loaded;
    gnt_nxt      = gnt;
    done_nxt     = 1'b0;
    rd_data_nxt  = rd_data;
    rd_valid_nxt = 1'b0;
    rd_err_nxt   = 1'b0;
    rf_mode_nxt  = 1'b0;
    rf_din_nxt   = 1'b0;
    rf_in_nxt    = rf_in;
    win_found    = 1'b0;
    win_idx      = '0;

    // First pending request searching upward from rr_ptr with wrap.
    for (int unsigned k = 0; k < N_REQ; k++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((32'(rr_ptr) + k) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end

    case (state)
      IDLE: begin
        if (win_found) begin
          gnt_nxt          = '0;
          gnt_nxt[win_idx] = 1'b1;
          gnt_idx_nxt      = win_idx;
          if (req_wr[win_idx]) begin
            state_nxt  = WR;
            rf_din_nxt = 1'b1;
            rf_in_nxt  = req_data[32'(win_idx)*W +: W];
          end else if (loaded) begin
            state_nxt   = RD_SETUP;
            rf_mode_nxt = 1'b1;
          end else begin
            state_nxt   = DONE;
            done_nxt    = 1'b1;
            rd_err_nxt  = 1'b1;
            rd_data_nxt = '0;
          end
        end
      end
      WR: begin
        loaded_nxt = 1'b1;
        state_nxt  = DONE;
        done_nxt   = 1'b1;
      end
      RD_SETUP: begin
        state_nxt   = RD_CAP;
        rf_mode_nxt = 1'b1;
      end
      RD_CAP: begin
        state_nxt    = DONE;
        rd_data_nxt  = rf_out;
        rd_valid_nxt = 1'b1;
        done_nxt     = 1'b1;
      end
      DONE: begin
        state_nxt  = IDLE;
        gnt_nxt    = '0;
        rr_ptr_nxt = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural model of the storage register.
module tb_regfile_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N-1:0]   req_wr;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           done;
  logic [W-1:0]   rd_data;
  logic           rd_valid;
  logic           rd_err;
  logic           rf_mode;
  logic           rf_din;
  logic [W-1:0]   rf_in;
  logic           rf_reset;
  logic [W-1:0]   rf_out;

  logic [W-1:0]   store;
  int             errors = 0;
  int             checks = 0;
  int             overlap = 0;

  int             op_lat, op_din_cnt, op_mode_cnt;
  logic [N-1:0]   op_gnt;
  logic [W-1:0]   op_din_val, op_rdd;
  logic           op_rdv, op_rde;

  regfile_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_data(req_data),
    .gnt(gnt), .done(done), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
    .rf_mode(rf_mode), .rf_din(rf_din), .rf_in(rf_in), .rf_reset(rf_reset), .rf_out(rf_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage register model: loads on din, drives out only in mode.
  always @(posedge clk) begin
    if (rf_reset) store <= '0;
    else if (rf_din) store <= rf_in;
  end
  assign rf_out = rf_mode ? store : '0;

  always @(negedge clk) if (!reset && rf_din && rf_mode) overlap++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  // Issue one request in an IDLE cycle, record what happens until done, return in the next IDLE cycle.
  task run_op(input int idx, input bit wr, input logic [W-1:0] data);
    req[idx]            = 1'b1;
    req_wr[idx]         = wr;
    req_data[idx*W +: W] = data;
    op_lat = 0; op_din_cnt = 0; op_mode_cnt = 0; op_din_val = '0;
    do begin
      @(negedge clk);
      op_lat++;
      if (rf_din) begin op_din_cnt++; op_din_val = rf_in; end
      if (rf_mode) op_mode_cnt++;
    end while (!done && op_lat < 20);
    op_gnt = gnt; op_rdv = rd_valid; op_rde = rd_err; op_rdd = rd_data;
    check("op_done", 32'(done), 32'd1);
    req[idx] = 1'b0;
    @(negedge clk);
  endtask

  task do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; req = '0; req_wr = '0; req_data = '0;

    // 1: reset values, stretched rf_reset, unloaded read
    @(negedge clk);
    check("rst_rf_reset", 32'(rf_reset), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("rst_rf_reset2", 32'(rf_reset), 32'd1);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd", {rd_valid, rd_err, rd_data}, 32'd0);
    check("rst_rfctl", {rf_mode, rf_din, rf_in}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rf_reset_stretch", 32'(rf_reset), 32'd1);
    @(negedge clk);
    check("rf_reset_off", 32'(rf_reset), 32'd0);
    run_op(0, 1'b0, 16'h0);
    check("t1_lat", op_lat, 32'd1);
    check("t1_gnt", 32'(op_gnt), 32'b0001);
    check("t1_err", {op_rde, op_rdv}, 32'b10);
    check("t1_rdd", 32'(op_rdd), 32'h0000);
    check("t1_mode", op_mode_cnt, 32'd0);

    // 2: write then loaded read by another requester
    run_op(1, 1'b1, 16'hA5C3);
    check("t2w_lat", op_lat, 32'd2);
    check("t2w_gnt", 32'(op_gnt), 32'b0010);
    check("t2w_din_cnt", op_din_cnt, 32'd1);
    check("t2w_din_val", 32'(op_din_val), 32'hA5C3);
    check("t2w_flags", {op_rde, op_rdv}, 32'b00);
    run_op(2, 1'b0, 16'h0);
    check("t2r_lat", op_lat, 32'd3);
    check("t2r_gnt", 32'(op_gnt), 32'b0100);
    check("t2r_rdd", 32'(op_rdd), 32'hA5C3);
    check("t2r_flags", {op_rde, op_rdv}, 32'b01);
    check("t2r_mode", op_mode_cnt, 32'd2);

    // 3: all four reading from rr_ptr=0 -> served 0,1,2,3
    do_reset();
    req_wr = '0;
    req = 4'hF;
    for (int k = 0; k < 4; k++) begin
      wait_done("t3_done");
      check("t3_gnt", 32'(gnt), 32'(1) << k);
      check("t3_err", 32'(rd_err), 32'd1);
      req = req & ~gnt;
    end
    @(negedge clk);

    // 4: reset during the WR cycle aborts and clears loaded
    req[3] = 1'b1; req_wr[3] = 1'b1; req_data[3*W +: W] = 16'h1234;
    @(negedge clk);
    check("t4_in_wr", {rf_din, rf_in}, {15'd0, 1'b1, 16'h1234});
    reset = 1'b1; req = '0;
    @(negedge clk);
    check("t4_gnt", 32'(gnt), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    check("t4_rfctl", {rf_mode, rf_din, rf_in}, 32'd0);
    check("t4_rf_reset", 32'(rf_reset), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    run_op(3, 1'b0, 16'h0);
    check("t4_lat", op_lat, 32'd1);
    check("t4_err", {op_rde, op_rdv}, 32'b10);

    // 5: req and data dropped mid-write; latched value still lands
    req[0] = 1'b1; req_wr[0] = 1'b1; req_data[0 +: W] = 16'hFFFF;
    @(negedge clk);
    req[0] = 1'b0; req_data[0 +: W] = 16'h0000;
    begin
      int pulses = 0;
      if (done) pulses++;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (done) pulses++;
      end
      check("t5_pulses", pulses, 32'd1);
    end
    run_op(1, 1'b0, 16'h0);
    check("t5_rdd", 32'(op_rdd), 32'hFFFF);
    check("t5_flags", {op_rde, op_rdv}, 32'b01);

    // 6: index 2 held high, index 1 pending -> rotation goes 2,1,2
    req_wr = '0;
    req = 4'b0110;
    wait_done("t6_done_a");
    check("t6_gnt_a", 32'(gnt), 32'b0100);
    check("t6_rdd_a", 32'(rd_data), 32'hFFFF);
    wait_done("t6_done_b");
    check("t6_gnt_b", 32'(gnt), 32'b0010);
    req[1] = 1'b0;
    wait_done("t6_done_c");
    check("t6_gnt_c", 32'(gnt), 32'b0100);
    req[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t6_idle_gnt", 32'(gnt), 32'd0);

    check("din_mode_overlap", overlap, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Controller and arbiter that shares the 16-bit storage register block among N_REQ requesters.
- Accepts read and write requests, picks one round-robin, and sequences the register's control inputs (mode, din, in, reset) over several cycles.
- Returns read data or write completion to the granted requester through a req/gnt/done handshake.
- Sits between the datapath requesters (ALU, load unit, debug port) and the storage register.

Parameters:
N_REQ, 4, number of requesters (2..8)
W, 16, data width; matches the storage register width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req  input  N_REQ  per-requester request, level; held until done
req_wr  input  N_REQ  per-requester op: 1=write, 0=read; sampled with req
req_data  input  N_REQ*W  per-requester write data; slice i = bits [i*W +: W]
gnt  output  N_REQ  one-hot grant; held for the whole operation
done  output  1  one-cycle completion pulse to the granted requester
rd_data  output  W  read result; valid when done & rd_valid
rd_valid  output  1  high with done for a read that returned stored data
rd_err  output  1  high with done for a read of a never-written register
rf_mode  output  1  to register mode input (1 = drive out)
rf_din  output  1  to register din input (1 = load in)
rf_in  output  W  to register in input
rf_reset  output  1  to register reset input
rf_out  input  W  from register out

Behaviour:
- Reset (synchronous; takes priority over everything, including an operation in progress):
  - state=IDLE; gnt=0, done=0, rd_valid=0, rd_err=0, rd_data=0.
  - rf_mode=0, rf_din=0, rf_in=0.
  - rr_ptr=0; loaded flag=0.
  - rf_reset=1 during every reset cycle and the one cycle after reset deasserts (stretched); 0 otherwise.
- States: IDLE, WR, RD_SETUP, RD_CAP, DONE.
- IDLE:
  - If any req bit is high, choose the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ... N_REQ-1, 0, ...).
  - Register the winner's one-hot gnt, op and data.
  - Next state: WR if req_wr=1. For a read: RD_SETUP if loaded=1, else DONE with rd_err pending.
  - No req: stay in IDLE; all control outputs 0.
- WR (1 cycle):
  - rf_din=1, rf_mode=0, rf_in=latched data; loaded<=1; next DONE.
- RD_SETUP (1 cycle):
  - rf_mode=1, rf_din=0; next RD_CAP.
- RD_CAP (1 cycle):
  - rf_mode=1; rd_data<=rf_out; next DONE.
- DONE (1 cycle):
  - done=1; gnt still asserted.
  - rd_valid=1 for a loaded read; rd_err=1 (with rd_data=0) for an unloaded read; both 0 for a write.
  - rf_mode=0, rf_din=0.
  - rr_ptr <= (granted index + 1) mod N_REQ; next IDLE; gnt drops on the next cycle.
- Latency, req seen in IDLE at cycle 0:
  - write: done at cycle 2;
  - loaded read: done at cycle 3;
  - unloaded read: done at cycle 1.
- Back-to-back: the requester must drop req the cycle after done. A req still high in IDLE is treated as a new request, but rotation favours the others.
- Requester drops req mid-operation: the operation completes normally and done still pulses. There is no abort.
- req_wr and req_data are latched at grant. Changes after grant are ignored.
- rf_din and rf_mode are never both 1. rf_in holds its last value outside WR.
- rd_data holds its value until the next read capture or reset.
- Throughput: at most one operation in flight; no pipelining.

Test Plan:
1. Reset, then req[0] read -> done at cycle 1 with rd_err=1, rd_data=0x0000, rf_mode never asserted; rf_reset high for reset cycles plus 1.
2. req[1] write 0xA5C3 -> gnt=0b0010; rf_din=1, rf_in=0xA5C3 for exactly 1 cycle; done 2 cycles after req. Then req[2] read -> rd_data=0xA5C3, rd_valid=1, done 3 cycles after req.
3. All four req high (reads) from rr_ptr=0 -> grants in order 0,1,2,3, each ending with a done pulse; no requester granted twice before all others are served.
4. req[3] write 0x1234 starts, reset asserted in the WR cycle -> next cycle all outputs 0, state IDLE, loaded=0. A following read returns rd_err=1.
5. req[0] write 0xFFFF with req dropped in the WR cycle and req_data changed to 0x0000 -> the register still loads 0xFFFF and done pulses once; a subsequent read returns 0xFFFF.
6. req[2] held high continuously with req[1] also pending after serving index 2 -> next grant goes to index 1 (wrap from rr_ptr=3), not index 2.
